// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit-instruction core.
// Owns the PC, gates write strobes to their phase and runs the data-memory handshake.
module instr_sequencer #(
    parameter int              PC_W      = 10,
    parameter int              IW        = 9,
    parameter int              CNT_W     = 16,
    parameter logic [IW-1:0]   HALT_WORD = 9'h1FF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IW-1:0]     instr,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              alu_ne,
    input  logic              mem_ack,
    output logic [PC_W-1:0]   pc,
    output logic [IW-1:0]     ir,
    output logic              reg_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  ins_cnt
);

    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
    } state_t;

    state_t           state_reg;
    logic [2:0]       opcode;
    logic [PC_W-1:0]  pc_inc;
    logic [CNT_W-1:0] cyc_inc;
    logic [CNT_W-1:0] ins_inc;

    assign opcode  = ir[IW-1:IW-3];
    assign pc_inc  = pc + 1'b1;
    assign cyc_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
    assign ins_inc = (&ins_cnt) ? ins_cnt : ins_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            reg_we    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cyc_cnt   <= '0;
            ins_cnt   <= '0;
        end else begin
            if (busy)
                cyc_cnt <= cyc_inc;

            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg <= S_FETCH;
                        pc        <= '0;
                        cyc_cnt   <= '0;
                        ins_cnt   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir        <= instr;
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    if (ir == HALT_WORD) begin
                        state_reg <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        state_reg <= S_MEM;
                        mem_req   <= 1'b1;
                        mem_we    <= (opcode == OP_STORE);
                    end else if (opcode == OP_BNE) begin
                        // Branch retires straight out of EXEC; alu_ne is only valid here.
                        state_reg <= S_FETCH;
                        pc        <= alu_ne ? branch_target : pc_inc;
                        ins_cnt   <= ins_inc;
                    end else begin
                        state_reg <= S_WB;
                        reg_we    <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (mem_we) begin
                            state_reg <= S_FETCH;
                            pc        <= pc_inc;
                            ins_cnt   <= ins_inc;
                        end else begin
                            state_reg <= S_WB;
                            reg_we    <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    reg_we    <= 1'b0;
                    state_reg <= S_FETCH;
                    pc        <= pc_inc;
                    ins_cnt   <= ins_inc;
                end
                default: begin
                    state_reg <= S_IDLE;
                    reg_we    <= 1'b0;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level program model predicts
// the write-back, memory-ack and halt events; a monitor checks them as they appear.
module tb_instr_sequencer;

    localparam int PC_W  = 10;
    localparam int IW    = 9;
    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << PC_W;
    localparam int LIMIT = 24;
    localparam int K_WB = 0, K_MEM = 1, K_DONE = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [IW-1:0]    instr;
    logic [PC_W-1:0]  branch_target;
    logic             alu_ne;
    logic             mem_ack = 1'b0;
    logic [PC_W-1:0]  pc;
    logic [IW-1:0]    ir;
    logic             reg_we, mem_req, mem_we, busy, done;
    logic [CNT_W-1:0] cyc_cnt, ins_cnt;

    logic [IW-1:0]    rom  [DEPTH];
    logic [PC_W-1:0]  btab [DEPTH];
    int               dly  [DEPTH];
    bit               ne_tab [DEPTH];

    typedef struct {
        int kind;
        int t;
        int pc;
        int we;
        int cyc;
        int ins;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(.PC_W(PC_W), .IW(IW), .CNT_W(CNT_W), .HALT_WORD(9'h1FF)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
        .branch_target(branch_target), .alu_ne(alu_ne), .mem_ack(mem_ack),
        .pc(pc), .ir(ir), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
        .busy(busy), .done(done), .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
    );

    always #5 clk = ~clk;

    // ROM, branch LUT and ALU flag modelled as pure lookups on the current pc.
    assign instr         = rom[pc];
    assign branch_target = btab[pc];
    assign alu_ne        = ne_tab[pc] && (int'(ins_cnt) < LIMIT);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Memory responder: acks after dly[pc] wait cycles, random noise when idle.
    int wcnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            mem_ack = (wcnt == dly[pc]);
            wcnt++;
        end else begin
            wcnt = 0;
            mem_ack = ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows an observable event.
    int  k = 0;
    bit  prev_busy = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (busy && !prev_busy) k = 0;
        if (busy) chk("we_req_overlap", {63'd0, reg_we & mem_req}, 64'd0);
        if (reg_we) begin
            if (exp_q.size() == 0) chk("unexpected_wb", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("wb_kind", e.kind, K_WB);
                chk("wb_cycle", k, e.t);
                chk("wb_pc", pc, e.pc);
            end
        end
        if (mem_req && mem_ack) begin
            if (exp_q.size() == 0) chk("unexpected_mem", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("mem_kind", e.kind, K_MEM);
                chk("mem_cycle", k, e.t);
                chk("mem_pc", pc, e.pc);
                chk("mem_we", mem_we, e.we);
            end
        end
        if (done && !prev_done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("done_kind", e.kind, K_DONE);
                chk("done_cycle", k, e.t);
                chk("done_pc", pc, e.pc);
                chk("done_cyc_cnt", cyc_cnt, e.cyc);
                chk("done_ins_cnt", ins_cnt, e.ins);
                chk("done_busy", busy, 0);
            end
        end
        if (busy) k++;
        prev_busy = busy;
        prev_done = done;
    end

    task automatic clear_prog();
        for (int a = 0; a < DEPTH; a++) begin
            rom[a] = 9'h1FF; btab[a] = '0; dly[a] = 0; ne_tab[a] = 1'b0;
        end
    endtask

    task automatic fill_addr(input int a, input int n);
        logic [IW-1:0] w;
        w = 9'($urandom_range(0, 511));
        if (w == 9'h1FF) w = 9'h1C0;
        rom[a]    = w;
        btab[a]   = ($urandom_range(0, 3) == 0) ? 10'd1020 : 10'($urandom_range(0, n - 2));
        dly[a]    = $urandom_range(0, 3);
        ne_tab[a] = ($urandom_range(0, 1) == 1);
    endtask

    task automatic gen_prog(input int n, input bit force_wrap);
        clear_prog();
        for (int a = 0; a < n - 1; a++) fill_addr(a, n);
        for (int a = DEPTH - 4; a < DEPTH; a++) fill_addr(a, n);
        if (force_wrap) begin
            rom[0] = 9'b110_000_000; btab[0] = 10'd1020; ne_tab[0] = 1'b1;
        end
        rom[n - 1] = 9'h1FF;
    endtask

    // Instruction-level reference: per-opcode cycle costs and next-pc rules.
    task automatic model_run();
        int p = 0, base = 0, ins = 0, d;
        logic [IW-1:0] w;
        for (int n = 0; n < 4000; n++) begin
            w = rom[p];
            d = dly[p];
            if (w == 9'h1FF) begin
                exp_q.push_back('{K_DONE, base + 2, p, 0, base + 2, ins});
                return;
            end
            case (w[8:6])
                3'b011: begin
                    exp_q.push_back('{K_MEM, base + 3 + d, p, 0, 0, 0});
                    exp_q.push_back('{K_WB, base + 4 + d, p, 0, 0, 0});
                    base += 5 + d; p = (p + 1) % DEPTH;
                end
                3'b100: begin
                    exp_q.push_back('{K_MEM, base + 3 + d, p, 1, 0, 0});
                    base += 4 + d; p = (p + 1) % DEPTH;
                end
                3'b110: begin
                    base += 3;
                    p = (ne_tab[p] && ins < LIMIT) ? int'(btab[p]) : (p + 1) % DEPTH;
                end
                default: begin
                    exp_q.push_back('{K_WB, base + 3, p, 0, 0, 0});
                    base += 4; p = (p + 1) % DEPTH;
                end
            endcase
            ins++;
        end
        chk("model_terminates", 64'd0, 64'd1);
    endtask

    task automatic run_prog(input string tag);
        int c;
        model_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            start = (busy && !done) ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("run %s: pc=%0d ins_cnt=%0d cyc_cnt=%0d", tag, pc, ins_cnt, cyc_cnt);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_ir"}, ir, 0);
        chk({tag, "_ctl"}, {reg_we, mem_req, mem_we, busy, done}, 0);
        chk({tag, "_cyc"}, cyc_cnt, 0);
        chk({tag, "_ins"}, ins_cnt, 0);
    endtask

    initial begin
        int c;
        clear_prog();
        #23;
        check_all_zero("reset");
        @(negedge clk); reset_n = 1'b1;

        clear_prog();
        rom[0] = 9'b000_001_010;
        run_prog("add_halt");

        for (int r = 0; r < 6; r++) begin
            gen_prog(20, r == 0);
            run_prog($sformatf("random%0d", r));
        end

        // Abandon a load mid-wait with an asynchronous reset.
        clear_prog();
        rom[0] = 9'b011_000_001;
        dly[0] = 3;
        model_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (c = 0; c < 50 && !mem_req; c++) @(negedge clk);
        chk("mem_req_seen", mem_req, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {busy, done}, 0);
        $display("reset during MEM wait applied");

        clear_prog();
        rom[0] = 9'b101_000_011;
        run_prog("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
